// File: rtl/gpr_dump_unit_pkg.sv
// Shared constants and FSM state encoding for the GPR debug dump unit.
// The register file uses the same width constants so both ends agree.
package gpr_dump_unit_pkg;

    localparam int GPR_NUM_REGS = 32;
    localparam int GPR_ADDR_W   = 5;
    localparam int GPR_DATA_W   = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_SEND,
        ST_CSUM,
        ST_DONE
    } dump_state_t;

endpackage

// File: rtl/gpr_dump_unit_if.sv
// Valid/ready beat stream carrying one register index/value per beat.
// The dump unit drives it through the master modport.
interface gpr_dump_unit_if #(
    parameter int ADDR_W = gpr_dump_unit_pkg::GPR_ADDR_W,
    parameter int DATA_W = gpr_dump_unit_pkg::GPR_DATA_W
);

    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] out_index;
    logic [DATA_W-1:0] out_data;
    logic              out_last;

    modport master (
        output out_valid,
        output out_index,
        output out_data,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_index,
        input  out_data,
        input  out_last,
        output out_ready
    );

endinterface

// File: rtl/gpr_dump_unit.sv
// Walks the GPR debug read port from FIRST_REG upward and streams each register as a beat.
// Optional trailing XOR checksum beat is enabled by defining GPR_DUMP_CHECKSUM_EN.
module gpr_dump_unit
    import gpr_dump_unit_pkg::*;
#(
    parameter int NUM_REGS  = GPR_NUM_REGS,
    parameter int ADDR_W    = GPR_ADDR_W,
    parameter int DATA_W    = GPR_DATA_W,
    parameter int FIRST_REG = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rf_raddr,
    input  logic [DATA_W-1:0] rf_rdata,
    gpr_dump_unit_if.master   dump
);

    localparam logic [ADDR_W-1:0] FIRST_IDX = ADDR_W'(FIRST_REG);
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_REGS - 1);
`ifdef GPR_DUMP_CHECKSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif

    dump_state_t       state;
    dump_state_t       stateNext;
    logic [ADDR_W-1:0] counter;
    logic              handshake;
    logic              atLast;

    assign rf_raddr  = counter;
    assign handshake = dump.out_valid && dump.out_ready;
    assign atLast    = (counter == LAST_IDX);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    stateNext = ST_READ;
                end
            end
            ST_READ: begin
                stateNext = ST_SEND;
            end
            ST_SEND: begin
                if (handshake) begin
                    if (!atLast) begin
                        stateNext = ST_READ;
                    end else begin
`ifdef GPR_DUMP_CHECKSUM_EN
                        stateNext = ST_CSUM;
`else
                        stateNext = ST_DONE;
`endif
                    end
                end
            end
            ST_CSUM: begin
`ifdef GPR_DUMP_CHECKSUM_EN
                if (handshake) begin
                    stateNext = ST_DONE;
                end
`else
                stateNext = ST_IDLE;
`endif
            end
            ST_DONE: begin
                stateNext = ST_IDLE;
            end
            default: begin
                stateNext = ST_IDLE;
            end
        endcase
    end

`ifdef GPR_DUMP_CHECKSUM_EN
    logic [DATA_W-1:0] checksum;

    // Folds in every register value as it is captured, so it is complete once the last beat is sent
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            checksum <= '0;
        end else if (state == ST_IDLE && start) begin
            checksum <= '0;
        end else if (state == ST_READ) begin
            checksum <= checksum ^ rf_rdata;
        end
    end
`endif

    // Beat registers are loaded in READ and held through SEND; busy/done follow the next state
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            counter        <= FIRST_IDX;
            busy           <= 1'b0;
            done           <= 1'b0;
            dump.out_valid <= 1'b0;
            dump.out_index <= '0;
            dump.out_data  <= '0;
            dump.out_last  <= 1'b0;
        end else begin
            busy <= (stateNext != ST_IDLE);
            done <= (stateNext == ST_DONE);
            case (state)
                ST_IDLE: begin
                    counter <= FIRST_IDX;
                end
                ST_READ: begin
                    dump.out_valid <= 1'b1;
                    dump.out_index <= counter;
                    dump.out_data  <= rf_rdata;
                    dump.out_last  <= atLast && !CSUM_EN;
                end
                ST_SEND: begin
                    if (handshake) begin
                        dump.out_valid <= 1'b0;
                        dump.out_last  <= 1'b0;
                        if (!atLast) begin
                            counter <= counter + ADDR_W'(1);
                        end
`ifdef GPR_DUMP_CHECKSUM_EN
                        else begin
                            dump.out_valid <= 1'b1;
                            dump.out_index <= '0;
                            dump.out_data  <= checksum;
                            dump.out_last  <= 1'b1;
                        end
`endif
                    end
                end
                ST_CSUM: begin
                    if (handshake) begin
                        dump.out_valid <= 1'b0;
                        dump.out_last  <= 1'b0;
                    end
                end
                ST_DONE: begin
                    counter <= FIRST_IDX;
                end
                default: begin
                    counter <= FIRST_IDX;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gpr_dump_unit.sv
// Directed, table-driven bench for gpr_dump_unit; follows GPR_DUMP_CHECKSUM_EN if defined.
module tb_gpr_dump_unit;
    import gpr_dump_unit_pkg::*;

    localparam int NR = GPR_NUM_REGS;
    localparam int AW = GPR_ADDR_W;
    localparam int DW = GPR_DATA_W;
`ifdef GPR_DUMP_CHECKSUM_EN
    localparam int CSUM_BEATS = 1;
`else
    localparam int CSUM_BEATS = 0;
`endif
    localparam int REG_BEATS = NR - 1;
    localparam int NBEATS    = REG_BEATS + CSUM_BEATS;
    localparam int DONE_EDGE = 2 * REG_BEATS + CSUM_BEATS;

    typedef struct {
        logic [DW-1:0] regVal;
        logic [AW-1:0] expIndex;
        logic [DW-1:0] expData;
        logic          expLast;
    } vec_t;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          busy;
    logic          done;
    logic [AW-1:0] rf_raddr;
    logic [DW-1:0] rf_rdata;
    logic [DW-1:0] gpr [NR];
    vec_t          tbl [NR];
    int            errors = 0;
    int            checks = 0;

    gpr_dump_unit_if #(.ADDR_W(AW), .DATA_W(DW)) dumpBus ();

    gpr_dump_unit #(.NUM_REGS(NR), .ADDR_W(AW), .DATA_W(DW), .FIRST_REG(1)) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .rf_raddr (rf_raddr),
        .rf_rdata (rf_rdata),
        .dump     (dumpBus)
    );

    assign rf_rdata = gpr[rf_raddr];

    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, actual, required);
        end
    endtask

    // Identity contents GPR[i]=i; the checksum beat of 1^2^..^31 is 0
    task automatic buildIdentity();
        for (int i = 0; i < REG_BEATS; i++) begin
            tbl[i] = '{regVal: DW'(i + 1), expIndex: AW'(i + 1), expData: DW'(i + 1),
                       expLast: (CSUM_BEATS == 0) && (i == REG_BEATS - 1)};
        end
        tbl[NR-1] = '{regVal: '0, expIndex: '0, expData: 32'h0000_0000, expLast: 1'b1};
    endtask

    task automatic applyStimulus();
        gpr[0] = '0;
        for (int i = 0; i < REG_BEATS; i++) begin
            gpr[tbl[i].expIndex] = tbl[i].regVal;
        end
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, ".busy"}, 64'(busy), 64'd0);
        checkOutput({tag, ".done"}, 64'(done), 64'd0);
        checkOutput({tag, ".valid"}, 64'(dumpBus.out_valid), 64'd0);
        checkOutput({tag, ".raddr"}, 64'(rf_raddr), 64'd1);
    endtask

    task automatic runDump(input string tag, input int stallIdx, input int stallLen,
                           input int busyStartIdx, input int resetIdx, input int expDone);
        int e;
        int beat;
        int stallLeft;
        int doneCount;
        int expEdge;
        bit restarted;
        bit finished;
        e = 0; beat = 0; stallLeft = stallLen; doneCount = 0;
        restarted = 1'b0; finished = 1'b0;
        @(negedge clock);
        start = 1'b1;
        dumpBus.out_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        checkOutput({tag, ".busyAfterStart"}, 64'(busy), 64'd1);
        while (!finished && e < 300) begin
            if (resetIdx >= 0 && dumpBus.out_valid && int'(dumpBus.out_index) == resetIdx) begin
                reset = 1'b0;
                start = 1'b0;
                #1;
                checkOutput({tag, ".rstBusy"}, 64'(busy), 64'd0);
                checkOutput({tag, ".rstDone"}, 64'(done), 64'd0);
                checkOutput({tag, ".rstValid"}, 64'(dumpBus.out_valid), 64'd0);
                checkOutput({tag, ".rstIndex"}, 64'(dumpBus.out_index), 64'd0);
                checkOutput({tag, ".rstData"}, 64'(dumpBus.out_data), 64'd0);
                checkOutput({tag, ".rstLast"}, 64'(dumpBus.out_last), 64'd0);
                checkOutput({tag, ".rstRaddr"}, 64'(rf_raddr), 64'd1);
                @(negedge clock);
                reset = 1'b1;
                return;
            end
            if (dumpBus.out_valid && stallIdx >= 0 && int'(dumpBus.out_index) == stallIdx
                && beat < REG_BEATS && stallLeft > 0) begin
                dumpBus.out_ready = 1'b0;
                stallLeft--;
            end else begin
                dumpBus.out_ready = 1'b1;
            end
            if (busyStartIdx >= 0 && !restarted && dumpBus.out_valid
                && int'(dumpBus.out_index) == busyStartIdx) begin
                start = 1'b1;
                restarted = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (dumpBus.out_valid) begin
                if (beat < NBEATS) begin
                    checkOutput({tag, ".index"}, 64'(dumpBus.out_index), 64'(tbl[beat].expIndex));
                    checkOutput({tag, ".data"}, 64'(dumpBus.out_data), 64'(tbl[beat].expData));
                    checkOutput({tag, ".last"}, 64'(dumpBus.out_last), 64'(tbl[beat].expLast));
                    if (dumpBus.out_ready) begin
                        if (beat < REG_BEATS) begin
                            expEdge = 2 * beat + 2;
                        end else begin
                            expEdge = 2 * REG_BEATS + 1;
                        end
                        if (stallIdx >= 0 && (beat >= REG_BEATS || int'(tbl[beat].expIndex) >= stallIdx)) begin
                            expEdge += stallLen;
                        end
                        checkOutput({tag, ".beatEdge"}, 64'(e + 1), 64'(expEdge));
                        beat++;
                    end
                end else begin
                    checkOutput({tag, ".extraBeat"}, 64'(beat), 64'(NBEATS - 1));
                end
            end
            if (done) begin
                doneCount++;
                checkOutput({tag, ".doneEdge"}, 64'(e), 64'(expDone));
                checkOutput({tag, ".beatCount"}, 64'(beat), 64'(NBEATS));
                finished = 1'b1;
            end
            @(posedge clock);
            e++;
            @(negedge clock);
        end
        start = 1'b0;
        dumpBus.out_ready = 1'b1;
        if (!finished) begin
            errors++;
            checks++;
            $display("[TB] FAIL %s.timeout actual=no done after %0d cycles required=done", tag, e);
        end
        checkIdleOutputs({tag, ".after"});
        repeat (3) @(negedge clock);
        checkOutput({tag, ".stayIdle"}, 64'(busy), 64'd0);
        checkOutput({tag, ".doneCount"}, 64'(doneCount), 64'd1);
    endtask

    initial begin
        dumpBus.out_ready = 1'b0;
        buildIdentity();
        applyStimulus();
        repeat (3) @(posedge clock);
        @(negedge clock);
        checkIdleOutputs("reset");
        checkOutput("reset.index", 64'(dumpBus.out_index), 64'd0);
        checkOutput("reset.data", 64'(dumpBus.out_data), 64'd0);
        checkOutput("reset.last", 64'(dumpBus.out_last), 64'd0);
        reset = 1'b1;
        @(negedge clock);
        checkIdleOutputs("idle");

        $display("[TB] identity dump");
        runDump("identity", -1, 0, -1, -1, DONE_EDGE);

        $display("[TB] backpressure on index 7");
        runDump("stall", 7, 5, -1, -1, DONE_EDGE + 5);

        $display("[TB] start while busy");
        runDump("busyStart", -1, 0, 10, -1, DONE_EDGE);

        $display("[TB] reset mid-dump");
        runDump("midReset", -1, 0, -1, 12, 0);
        @(negedge clock);
        checkIdleOutputs("postReset");
        runDump("restart", -1, 0, -1, -1, DONE_EDGE);

        // and $7,$5,$6 with GPR[5]=5, GPR[6]=6 writes 4; checksum 0^7^4 = 3
        $display("[TB] live register values");
        tbl[6].regVal  = tbl[4].regVal & tbl[5].regVal;
        tbl[6].expData = 32'h0000_0004;
        tbl[NR-1].expData = 32'h0000_0003;
        applyStimulus();
        runDump("live", -1, 0, -1, -1, DONE_EDGE);

        // GPR[1]=0xFFFFFFFF replaces 1 in the XOR: 0^1^0xFFFFFFFF = 0xFFFFFFFE
        $display("[TB] all-ones register 1");
        buildIdentity();
        tbl[0].regVal  = 32'hFFFF_FFFF;
        tbl[0].expData = 32'hFFFF_FFFF;
        tbl[NR-1].expData = 32'hFFFF_FFFE;
        applyStimulus();
        runDump("ones", -1, 0, -1, -1, DONE_EDGE);

        $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gpr_dump_unit.md
# gpr_dump_unit

Debug read-out engine for the pipeline CPU's general-purpose register file. On a start pulse it walks the register file through a dedicated read port, from register 1 up to the highest register. It emits each register's index and value as one beat on a valid/ready stream, so a host, UART bridge or bench monitor can collect the architectural state without hierarchical peeks. It sits beside the GPR and is the reading end of the register file's debug access; the CPU's own read/write ports are untouched.

## Interface
Parameters:
- NUM_REGS, 32, number of architectural registers; index range 0..NUM_REGS-1
- ADDR_W, 5, register index width; must satisfy 2**ADDR_W >= NUM_REGS
- DATA_W, 32, register data width
- FIRST_REG, 1, first index dumped; register 0 is skipped by default (hard-wired zero)

Ports (clock and reset first):
- clock  in  1  single system clock, rising edge
- reset  in  1  asynchronous, active-low reset; all state cleared while low
- start  in  1  request a dump; sampled only in IDLE
- busy  out  1  high from the cycle after start is accepted until DONE is left
- done  out  1  one-cycle pulse after the final beat handshakes
- rf_raddr  out  ADDR_W  read address to the GPR debug port
- rf_rdata  in  DATA_W  combinational read data for rf_raddr, same cycle
- out_valid  out  1  beat valid
- out_ready  in  1  consumer accepts beat
- out_index  out  ADDR_W  register index of current beat
- out_data  out  DATA_W  register value of current beat
- out_last  out  1  marks final beat of the dump

## Operation
- FSM states: IDLE, READ, SEND, CSUM (only with macro), DONE.
- IDLE: rf_raddr = FIRST_REG. start=1 moves to READ with the index counter set to FIRST_REG.
- READ: rf_rdata is captured into out_data and the counter into out_index. out_last is set if the counter = NUM_REGS-1 and checksum is disabled. Next state is SEND with out_valid=1.
- SEND: out_valid, out_index, out_data and out_last are held stable until out_valid&&out_ready.
  - On handshake with counter < NUM_REGS-1: counter+1, go to READ.
  - On handshake with counter = NUM_REGS-1: go to CSUM if enabled, else DONE.
- DONE: done=1 for exactly one cycle, then IDLE; busy drops on entering IDLE.
- start while busy is ignored. start held high in IDLE after DONE begins a new dump.
- Values reflect live register contents at each READ cycle. No snapshot is taken; concurrent CPU writes may appear mid-dump.
- Counter wrap: the counter never exceeds NUM_REGS-1; there is no wrap to 0.
- Reset while low: state=IDLE, counter=FIRST_REG, and all outputs are 0. This includes mid-dump; a partially sent dump is simply abandoned.

## Timing
- Reset values: busy=0, done=0, out_valid=0, out_index=0, out_data=0, out_last=0, rf_raddr=FIRST_REG.
- start sampled at edge E0: READ during E0..E1, out_valid=1 after E1.
- One beat per 2 cycles at best (READ+SEND); out_valid deasserts for one cycle between beats.
- With out_ready tied high, beat k (k=0..NUM_REGS-FIRST_REG-1) handshakes at edge E(2k+2).
- Default parameters: last register beat at E62, done high during E62..E63 without checksum.
- out_valid never depends combinationally on out_ready. Outputs are registered except rf_raddr, which is driven from the counter register.

## Configuration
- GPR_DUMP_CHECKSUM_EN defined:
  - A running XOR of every emitted out_data is kept and cleared at start.
  - After the last register beat, CSUM emits one extra beat: out_index=0, out_data=XOR result, out_last=1.
  - The last register beat then has out_last=0. done follows the checksum handshake; with ready high it comes 1 cycle later (no READ needed).
- Undefined: no checksum register, no CSUM state, and out_last is on register NUM_REGS-1.

## Structure
- Shared package: FSM state encoding (IDLE/READ/SEND/CSUM/DONE) and default constants NUM_REGS, ADDR_W, DATA_W. The GPR and this unit share the same width constants.
- No sub-module is needed beyond the single FSM/datapath. The checksum accumulator is inline under the macro.

## Test plan
- Identity dump: GPR[i]=i, out_ready=1, pulse start -> 31 beats with index 1..31 and data 1..31, out_last on index 31, done at E62.
- Backpressure: out_ready low for 5 cycles during beat index 7 -> out_valid/out_index=7/out_data held stable, no skipped or duplicate beats, done delayed by exactly 5 cycles.
- Start while busy: pulse start again at beat 10 -> ignored, exactly 31 beats, a single done pulse.
- Reset mid-dump: assert reset at beat 12 -> all outputs 0 immediately. After release and start, the dump restarts at index 1.
- Live values: after CPU runs `and $7,$5,$6` with GPR[i]=i, dump -> beat index 7 carries 0x00000004.
- Checksum (macro defined), identity contents -> 32nd beat index 0, data 0x00000000, out_last=1; with GPR[1]=0xFFFFFFFF -> checksum 0xFFFFFFFE.
